// File: rtl/ps2_rtc_cmd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ps2_rtc_pkg
// Shared definitions for the PS/2 -> RTC command decoder:
//   - scan-code constants (set 2 make codes, break/extended prefixes)
//   - PS2 mode-select pulse codes
//   - prefix FSM state encoding
//   - layout of the pulse event vector fed to the stretcher
// No ports (package).
// ----------------------------------------------------------------------------
package ps2_rtc_pkg;

    // Push-button keys
    localparam logic [7:0] SC_UP      = 8'h1D;
    localparam logic [7:0] SC_DOWN    = 8'h1B;
    localparam logic [7:0] SC_LEFT    = 8'h1C;
    localparam logic [7:0] SC_RIGHT   = 8'h23;
    localparam logic [7:0] SC_PROGRAM = 8'h4D;

    // Mode-select keys
    localparam logic [7:0] SC_MODE_E  = 8'h24;
    localparam logic [7:0] SC_MODE_R  = 8'h2D;
    localparam logic [7:0] SC_MODE_I  = 8'h43;

    // Toggle keys and clear
    localparam logic [7:0] SC_TIMER   = 8'h2C;
    localparam logic [7:0] SC_24_12   = 8'h2B;
    localparam logic [7:0] SC_AM_PM   = 8'h2A;
    localparam logic [7:0] SC_ESC     = 8'h76;

    // Prefixes
    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    // PS2 mode-select codes
    localparam logic [2:0] PS2_IDLE = 3'b000;
    localparam logic [2:0] PS2_E    = 3'b010;
    localparam logic [2:0] PS2_RI   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // One event vector drives every stretched output, so a new event
    // replaces whatever pulse is currently active.
    typedef struct packed {
        logic [2:0] ps2;
        logic       pb_program;
        logic       pb_up;
        logic       pb_down;
        logic       pb_left;
        logic       pb_right;
    } evt_t;

endpackage

// File: rtl/ps2_rtc_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_rtc_cmd_decoder_if
// Bundle between the PS/2 receiver side and the RTC control side.
//   key_code / listo        : scan-code byte and byte-valid from the receiver
//   var_stb                 : one-cycle "byte accepted" strobe
//   PS2                     : mode-select pulse code
//   SF_*                    : held toggle flags
//   PB_*_SA                 : stretched push-button pulses
// Modports: master = byte source / output consumer, slave = decoder.
// ----------------------------------------------------------------------------
interface ps2_rtc_cmd_decoder_if #(
    parameter int KEY_W = 8
);
    logic [KEY_W-1:0] key_code;
    logic             listo;
    logic             var_stb;
    logic [2:0]       PS2;
    logic             SF_Timer;
    logic             SF_24_12;
    logic             SF_AM_PM;
    logic             PB_program_SA;
    logic             PB_up_SA;
    logic             PB_down_SA;
    logic             PB_left_SA;
    logic             PB_right_SA;

    modport master (
        output key_code, listo,
        input  var_stb, PS2, SF_Timer, SF_24_12, SF_AM_PM,
               PB_program_SA, PB_up_SA, PB_down_SA, PB_left_SA, PB_right_SA
    );

    modport slave (
        input  key_code, listo,
        output var_stb, PS2, SF_Timer, SF_24_12, SF_AM_PM,
               PB_program_SA, PB_up_SA, PB_down_SA, PB_left_SA, PB_right_SA
    );
endinterface

// File: rtl/ps2_rtc_cmd_decoder_pulse_stretch.sv
// ----------------------------------------------------------------------------
// ps2_rtc_pulse_stretch
// Latches an event vector and holds it for PULSE_CYCLES clocks using one
// shared down-counter. A load while active replaces the vector and restarts
// the count with no gap cycle. The counter never wraps; it rests at 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load strobe (event present this cycle)
//   i_vec        event vector to latch
//   o_vec        stretched vector
// ----------------------------------------------------------------------------
module ps2_rtc_pulse_stretch #(
    parameter int PULSE_CYCLES = 4,
    parameter int VEC_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [VEC_W-1:0] i_vec,
    output logic [VEC_W-1:0] o_vec
);
    localparam int               CNT_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [VEC_W-1:0] r_vec;

    // Count value is the number of cycles the output still stays high,
    // including the current one; the last cycle clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_LOAD;
            r_vec <= i_vec;
        end else if (r_cnt == CNT_ONE) begin
            r_cnt <= '0;
            r_vec <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_vec = r_vec;
endmodule

// File: rtl/ps2_rtc_cmd_decoder.sv
// ----------------------------------------------------------------------------
// ps2_rtc_cmd_decoder
// Turns the PS/2 receiver byte stream into registered RTC controls:
// held toggle flags (with typematic suppression), stretched push-button
// pulses, a PS2 mode-select pulse code and a byte-accepted strobe.
// Tracks F0 (break) and E0 (extended) prefixes with a small FSM.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       ps2_rtc_cmd_decoder_if.slave (key_code/listo in, controls out)
// Optional feature macro: PS2_RTC_ARROWS_EN -- when defined, extended
// E0 75/72/6B/74 makes fire up/down/left/right pulses; otherwise extended
// makes only produce the accept strobe.
// ----------------------------------------------------------------------------
module ps2_rtc_cmd_decoder
    import ps2_rtc_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int KEY_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ps2_rtc_cmd_decoder_if.slave bus
);
`ifdef PS2_RTC_ARROWS_EN
    localparam bit ARROWS_EN = 1'b1;
`else
    localparam bit ARROWS_EN = 1'b0;
`endif

    logic             r_listo_d, r_listo_d2;
    logic [KEY_W-1:0] r_key_d;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_held, r_flags;      // bit 2 Timer, 1 24_12, 0 AM_PM
    logic             r_var;
    logic             w_accept, w_make, w_ext_make, w_esc;
    logic [2:0]       w_tgl_key, w_held_set, w_held_clr, w_tgl;
    evt_t             w_evt, w_pulse;

    // Byte and listo are captured together; the rising edge of the captured
    // listo is the single acceptance point, so a long listo is one byte.
    assign w_accept = r_listo_d & ~r_listo_d2;

    always_comb begin
        w_tgl_key = 3'b000;
        case (r_key_d)
            KEY_W'(SC_TIMER): w_tgl_key = 3'b100;
            KEY_W'(SC_24_12): w_tgl_key = 3'b010;
            KEY_W'(SC_AM_PM): w_tgl_key = 3'b001;
            default:          w_tgl_key = 3'b000;
        endcase
    end

    // Prefix FSM: next state and which kind of byte this is
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_ext_make  = 1'b0;
        w_held_clr  = 3'b000;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_key_d == KEY_W'(SC_BREAK))      w_state_nxt = ST_BRK;
                    else if (r_key_d == KEY_W'(SC_EXT))   w_state_nxt = ST_EXT;
                    else                                  w_make      = 1'b1;
                end
                ST_BRK: begin
                    w_held_clr  = w_tgl_key;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    if (r_key_d == KEY_W'(SC_BREAK)) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_ext_make  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;  // ST_EXT_BRK: byte consumed
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Make-code decode into pulse events / Esc
    always_comb begin
        w_evt = '0;
        w_esc = 1'b0;
        if (w_make) begin
            case (r_key_d)
                KEY_W'(SC_PROGRAM):                   w_evt.pb_program = 1'b1;
                KEY_W'(SC_UP):                        w_evt.pb_up      = 1'b1;
                KEY_W'(SC_DOWN):                      w_evt.pb_down    = 1'b1;
                KEY_W'(SC_LEFT):                      w_evt.pb_left    = 1'b1;
                KEY_W'(SC_RIGHT):                     w_evt.pb_right   = 1'b1;
                KEY_W'(SC_MODE_E):                    w_evt.ps2        = PS2_E;
                KEY_W'(SC_MODE_R), KEY_W'(SC_MODE_I): w_evt.ps2        = PS2_RI;
                KEY_W'(SC_ESC):                       w_esc            = 1'b1;
                default:                              ;
            endcase
        end else if (w_ext_make && ARROWS_EN) begin
            case (r_key_d)
                KEY_W'(SC_EXT_UP):    w_evt.pb_up    = 1'b1;
                KEY_W'(SC_EXT_DOWN):  w_evt.pb_down  = 1'b1;
                KEY_W'(SC_EXT_LEFT):  w_evt.pb_left  = 1'b1;
                KEY_W'(SC_EXT_RIGHT): w_evt.pb_right = 1'b1;
                default:              ;
            endcase
        end
    end

    // A toggle fires only on the first make while the key is not held;
    // typematic repeats find the held bit set and do nothing.
    assign w_held_set = w_make ? w_tgl_key : 3'b000;
    assign w_tgl      = w_held_set & ~r_held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_listo_d  <= 1'b0;
            r_listo_d2 <= 1'b0;
            r_key_d    <= '0;
            r_held     <= 3'b000;
            r_flags    <= 3'b000;
            r_var      <= 1'b0;
        end else begin
            r_listo_d  <= bus.listo;
            r_listo_d2 <= r_listo_d;
            r_key_d    <= bus.key_code;
            r_held     <= (r_held | w_held_set) & ~w_held_clr;
            r_flags    <= w_esc ? 3'b000 : (r_flags ^ w_tgl);
            r_var      <= w_accept;
        end
    end

    ps2_rtc_pulse_stretch #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .VEC_W        ($bits(evt_t))
    ) u_stretch (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_load (|w_evt),
        .i_vec  (w_evt),
        .o_vec  (w_pulse)
    );

    assign bus.var_stb       = r_var;
    assign bus.PS2           = w_pulse.ps2;
    assign bus.SF_Timer      = r_flags[2];
    assign bus.SF_24_12      = r_flags[1];
    assign bus.SF_AM_PM      = r_flags[0];
    assign bus.PB_program_SA = w_pulse.pb_program;
    assign bus.PB_up_SA      = w_pulse.pb_up;
    assign bus.PB_down_SA    = w_pulse.pb_down;
    assign bus.PB_left_SA    = w_pulse.pb_left;
    assign bus.PB_right_SA   = w_pulse.pb_right;
endmodule

// File: tb/tb_ps2_rtc_cmd_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_rtc_cmd_decoder
// Directed bench for ps2_rtc_cmd_decoder (PULSE_CYCLES = 4). Inputs change
// and outputs are sampled on the falling clock edge. The output vector is
// {var, PS2[2:0], SF_Timer, SF_24_12, SF_AM_PM, PB program/up/down/left/right}.
// Honours PS2_RTC_ARROWS_EN for the extended-key expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_rtc_cmd_decoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] obs;
    logic [11:0] exp_v;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ps2_rtc_cmd_decoder_if #(.KEY_W(8)) bus ();

    ps2_rtc_cmd_decoder #(
        .PULSE_CYCLES (4),
        .KEY_W        (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign obs = {bus.var_stb, bus.PS2, bus.SF_Timer, bus.SF_24_12, bus.SF_AM_PM,
                  bus.PB_program_SA, bus.PB_up_SA, bus.PB_down_SA,
                  bus.PB_left_SA, bus.PB_right_SA};

    // One byte: listo high one cycle, low one cycle. Returns on the falling
    // edge where that byte's effects first become visible.
    task automatic send(input logic [7:0] code);
        bus.key_code = code;
        bus.listo    = 1'b1;
        @(negedge clk);
        bus.listo    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.listo    = 1'b0;
        bus.key_code = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 12'b0_000_000_00000) begin
            $display("FAIL reset_state: got %b want %b", obs, 12'b0_000_000_00000); n_fail++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        send(8'h1D);
        n_cmp++;
        if (obs !== 12'b1_000_000_01000) begin
            $display("FAIL pre_reset_up: got %b want %b", obs, 12'b1_000_000_01000); n_fail++;
        end
        send(8'hF0);  // pulse still active, FSM now waiting for a break byte
        n_cmp++;
        if (obs !== 12'b1_000_000_01000) begin
            $display("FAIL pre_reset_brk: got %b want %b", obs, 12'b1_000_000_01000); n_fail++;
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 12'b0_000_000_00000) begin
            $display("FAIL reset_async: got %b want %b", obs, 12'b0_000_000_00000); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 12'b0_000_000_00000) begin
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 12'b0_000_000_00000); n_fail++;
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        // FSM back in IDLE: 2C is a make and toggles the timer flag
        send(8'h2C);
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL reset_fsm_idle: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
    endtask

    task automatic test_listo_hold();
        bus.key_code = 8'h1D;
        bus.listo    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_v = {(i == 2), 3'b000, 3'b100, 1'b0, (i >= 2 && i <= 5), 3'b000};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL listo_hold[%0d]: got %b want %b", i, obs, exp_v); n_fail++;
            end
            if (i == 5) bus.listo = 1'b0;
        end
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 3; i++) begin
            send(8'h2B);
            n_cmp++;
            if (obs !== 12'b1_000_110_00000) begin
                $display("FAIL typematic_make[%0d]: got %b want %b", i, obs, 12'b1_000_110_00000); n_fail++;
            end
        end
        send(8'hF0);
        send(8'h2B);
        n_cmp++;
        if (obs !== 12'b1_000_110_00000) begin
            $display("FAIL typematic_break: got %b want %b", obs, 12'b1_000_110_00000); n_fail++;
        end
        send(8'h2B);
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL typematic_retoggle: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== 12'b0_000_100_00000) begin
            $display("FAIL var_one_cycle: got %b want %b", obs, 12'b0_000_100_00000); n_fail++;
        end
    endtask

    task automatic test_pulse_replace();
        send(8'h24);
        n_cmp++;
        if (obs !== 12'b1_010_100_00000) begin
            $display("FAIL replace_e: got %b want %b", obs, 12'b1_010_100_00000); n_fail++;
        end
        bus.key_code = 8'h2D;
        bus.listo    = 1'b1;
        for (int i = 3; i <= 8; i++) begin
            @(negedge clk);
            bus.listo = 1'b0;
            if (i == 3)      exp_v = 12'b0_010_100_00000;
            else if (i == 4) exp_v = 12'b1_100_100_00000;
            else if (i <= 7) exp_v = 12'b0_100_100_00000;
            else             exp_v = 12'b0_000_100_00000;
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL replace[%0d]: got %b want %b", i, obs, exp_v); n_fail++;
            end
        end
    endtask

    task automatic test_pb_keys();
        logic [7:0]  codes [6] = '{8'h4D, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43};
        logic [11:0] exps  [6] = '{12'b1_000_100_10000, 12'b1_000_100_01000,
                                   12'b1_000_100_00100, 12'b1_000_100_00010,
                                   12'b1_000_100_00001, 12'b1_100_100_00000};
        for (int i = 0; i < 6; i++) begin
            send(codes[i]);
            n_cmp++;
            if (obs !== exps[i]) begin
                $display("FAIL pb_key_%h: got %b want %b", codes[i], obs, exps[i]); n_fail++;
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs !== 12'b0_000_100_00000) begin
            $display("FAIL pb_expire: got %b want %b", obs, 12'b0_000_100_00000); n_fail++;
        end
        send(8'h15);  // unmapped make
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL unmapped: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
    endtask

    task automatic test_extended();
        send(8'hE0);
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL ext_prefix: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
        send(8'h75);
`ifdef PS2_RTC_ARROWS_EN
        exp_v = 12'b1_000_100_01000;
`else
        exp_v = 12'b1_000_100_00000;
`endif
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL ext_up: got %b want %b", obs, exp_v); n_fail++;
        end
        repeat (4) @(negedge clk);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL ext_break: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
        send(8'h1D);  // FSM must be back in IDLE
        n_cmp++;
        if (obs !== 12'b1_000_100_01000) begin
            $display("FAIL ext_back_idle: got %b want %b", obs, 12'b1_000_100_01000); n_fail++;
        end
    endtask

    task automatic test_esc();
        send(8'hF0); send(8'h2C);   // release held timer and 24/12 keys
        send(8'hF0); send(8'h2B);
        send(8'h2B);
        send(8'h2A);
        n_cmp++;
        if (obs !== 12'b1_000_111_00000) begin
            $display("FAIL esc_setup: got %b want %b", obs, 12'b1_000_111_00000); n_fail++;
        end
        send(8'h76);
        n_cmp++;
        if (obs !== 12'b1_000_000_00000) begin
            $display("FAIL esc_clear: got %b want %b", obs, 12'b1_000_000_00000); n_fail++;
        end
        send(8'h2C);
        n_cmp++;
        if (obs !== 12'b1_000_100_00000) begin
            $display("FAIL esc_then_toggle: got %b want %b", obs, 12'b1_000_100_00000); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_listo_hold();
        test_typematic();
        test_pulse_replace();
        test_pb_keys();
        test_extended();
        test_esc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
